if_fetch: RTL
=============

# if_fetch

Instruction-fetch stage: owns the program counter, issues requests to instruction memory over a req/ack handshake, and presents fetched instructions to the IF/ID pipeline register. It is the producer end of the IF/ID interface: it drives the `pc`/`instr` pair that IF/ID latches, and honours the same `hazard_i`, `stall_i` and redirect conditions. A one-entry buffer holds a fetched instruction while the downstream stage is not accepting.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, address of the first fetch after reset.

Ports:
- clk_i  in  1  clock, all state updates on the rising edge.
- rst_i  in  1  reset, asynchronous, active-low.
- start_i  in  1  level; fetching begins the first cycle it is high after reset.
- hazard_i  in  1  load-use hold from hazard detection; downstream not accepting.
- stall_i  in  1  global pipeline stall (data-cache miss); downstream not accepting.
- redirect_i  in  1  taken branch or jump; single-cycle pulse.
- target_i  in  32  redirect target address, valid with redirect_i.
- imem_req_o  out  1  instruction-memory request.
- imem_addr_o  out  32  request address, word aligned.
- imem_ack_i  in  1  response valid, may arrive in the same cycle as the request.
- imem_data_i  in  32  instruction word, valid with imem_ack_i.
- valid_o  out  1  pc_o/instr_o hold a real instruction.
- pc_o  out  32  fetched address + 4, or 0 when valid_o=0.
- instr_o  out  32  fetched instruction, or 32'h0 (NOP) when valid_o=0.

## Operation
- Accept condition: `accept = valid_o & ~hazard_i & ~stall_i`. IF/ID samples pc_o/instr_o every edge. An invalid buffer presents a NOP bubble.
- FSM states:
  - IDLE: after reset, until start_i=1, then go to FETCH.
  - FETCH: imem_req_o=1 whenever there is no outstanding request and either the buffer is empty or accept=1 this cycle.
  - DRAIN: a redirect occurred while a request was outstanding. Hold req/addr until ack, discard the data, then return to FETCH.
- Handshake rule: once imem_req_o rises, imem_req_o and imem_addr_o stay stable until the cycle in which imem_ack_i=1. The request drops after ack unless a new request is issued in the same cycle.
- On ack (not discarded): buffer <= {addr+4, data}, valid set; pc_q <= addr+4.
- Buffer clears on accept unless it is refilled in the same cycle.
- Redirect (highest priority):
  - pc_q <= target_i and the buffer is invalidated.
  - An ack in the same cycle is discarded.
  - An outstanding request without ack moves the FSM to DRAIN.
- Simultaneous ack and a not-accepting downstream: data goes into the empty buffer. A request is never issued while the buffer is full and not accepting, so data is never dropped.
- Address arithmetic is 32-bit modulo. 32'hFFFF_FFFC + 4 wraps to 0. target_i[1:0] is ignored (forced to 0).

## Timing
- Reset values:
  - imem_req_o=0, imem_addr_o=RESET_PC.
  - valid_o=0, pc_o=0, instr_o=0.
  - pc_q=RESET_PC, state IDLE.
- Reset asserted mid-request abandons the request immediately. Memory must tolerate a dropped req.
- Latency: start_i high in cycle 0 -> req in cycle 1 -> with zero-wait ack, valid_o in cycle 2.
- Throughput: one instruction per cycle with zero-wait memory and continuous accept.
- Redirect in cycle N -> request to target_i in cycle N+1 if nothing was outstanding. Otherwise the request is issued the cycle after the draining ack.
- valid_o, pc_o and instr_o are registered outputs. imem_req_o and imem_addr_o are combinational from state, pc_q and accept.

## Configuration
- IF_FETCH_PERF_EN defined: adds outputs `fetch_cnt_o[31:0]` (accepted instructions) and `bubble_cnt_o[31:0]` (cycles with valid_o=0 after start). Both reset to 0, wrap at 2^32, and do not count in IDLE.
- IF_FETCH_PERF_EN undefined: neither the ports nor the counters exist. All other behaviour is identical.

## Structure
- Shared package `cpu_pkg`:
  - fetch state enum {IDLE, FETCH, DRAIN}.
  - `NOP_INSTR` = 32'h0.
  - `PC_INC` = 32'd4.
- Sub-module `if_fetch_buf`: the one-entry pc/instr buffer with load, clear and accept. The FSM, PC register and handshake stay in if_fetch.

## Test plan
- Reset, start_i=1, zero-wait memory returning addr-tagged words, no stalls -> req at 0x0, 0x4, 0x8 on consecutive cycles; valid_o from cycle 2 with pc_o=0x4, 0x8, 0xC.
- 3-cycle ack latency -> req/addr held stable for 3 cycles; valid_o=0 (instr_o=0) between instructions; no duplicate fetch.
- hazard_i held 2 cycles while the buffer is full -> pc_o/instr_o unchanged, no new req; resumes with the next sequential address.
- redirect_i to 0x100 with a request to 0x10 outstanding -> state DRAIN; data from 0x10 never reaches valid_o; next req addr 0x100.
- redirect_i in the same cycle as ack -> data discarded, valid_o=0 next cycle, next fetch at target.
- rst_i asserted mid-request -> all outputs zero immediately; after release and start_i, fetching restarts at RESET_PC.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared fetch-stage types and constants.
//   fetch_state_t : fetch FSM states {IDLE, FETCH, DRAIN}
//   NOP_INSTR     : instruction word presented as a pipeline bubble
//   PC_INC        : sequential program-counter increment
package cpu_pkg;
    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} fetch_state_t;
    localparam logic [31:0] NOP_INSTR = 32'h0;
    localparam logic [31:0] PC_INC = 32'd4;
endpackage

// File: rtl/if_fetch_buf.sv
// if_fetch_buf: one-entry pc/instr holding buffer feeding the IF/ID register.
//   clk_i, rst_i      : clock, asynchronous active-low reset
//   load_i            : capture pc_i/instr_i and mark valid
//   clear_i           : invalidate (redirect), wins over load
//   accept_i          : downstream took the entry; empties unless reloaded
//   pc_i, instr_i     : incoming fetched pair
//   valid_o, pc_o, instr_o : registered entry; zeros when invalid
module if_fetch_buf
    import cpu_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        load_i,
    input  logic        clear_i,
    input  logic        accept_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] instr_i,
    output logic        valid_o,
    output logic [31:0] pc_o,
    output logic [31:0] instr_o
);
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid_o <= 1'b0;
            pc_o    <= 32'h0;
            instr_o <= NOP_INSTR;
        end else if (clear_i || (accept_i && !load_i)) begin
            valid_o <= 1'b0;
            pc_o    <= 32'h0;
            instr_o <= NOP_INSTR;
        end else if (load_i) begin
            valid_o <= 1'b1;
            pc_o    <= pc_i;
            instr_o <= instr_i;
        end
    end
endmodule

// File: rtl/if_fetch.sv
// if_fetch: instruction-fetch stage (PC, imem req/ack handshake, IF/ID producer).
//   clk_i, rst_i            : clock, asynchronous active-low reset
//   start_i                 : leave IDLE and begin fetching
//   hazard_i, stall_i       : downstream not accepting
//   redirect_i, target_i    : taken branch/jump and its target
//   imem_req_o, imem_addr_o : memory request, held stable until ack
//   imem_ack_i, imem_data_i : memory response (may be same cycle as req)
//   valid_o, pc_o, instr_o  : registered fetched pair (pc = addr + 4)
//   Optional IF_FETCH_PERF_EN adds fetch_cnt_o and bubble_cnt_o.
module if_fetch
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        hazard_i,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] target_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_data_i,
    output logic        valid_o,
    output logic [31:0] pc_o,
    output logic [31:0] instr_o
`ifdef IF_FETCH_PERF_EN
    ,
    output logic [31:0] fetch_cnt_o,
    output logic [31:0] bubble_cnt_o
`endif
);
    fetch_state_t state;
    logic [31:0]  pc_q;
    logic [31:0]  addr_q;
    logic         pend;
    logic         accept;
    logic         load;
    logic [31:0]  addr_inc;

    assign accept = valid_o & ~hazard_i & ~stall_i;
    // A pending request is held regardless of redirect; new requests are
    // suppressed in a redirect cycle so the next one goes to the target.
    assign imem_req_o  = pend | ((state == FETCH) & ~redirect_i & (~valid_o | accept));
    assign imem_addr_o = pend ? addr_q : pc_q;
    assign addr_inc    = imem_addr_o + PC_INC;
    assign load        = imem_req_o & imem_ack_i & (state == FETCH) & ~redirect_i;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state  <= IDLE;
            pc_q   <= RESET_PC;
            addr_q <= RESET_PC;
            pend   <= 1'b0;
        end else begin
            pend   <= imem_req_o & ~imem_ack_i;
            addr_q <= imem_addr_o;
            pc_q   <= redirect_i ? (target_i & ~32'd3) : load ? addr_inc : pc_q;
            state  <= (state == IDLE)  ? (start_i ? FETCH : IDLE) :
                      (state == DRAIN) ? (imem_ack_i ? FETCH : DRAIN) :
                      (redirect_i & imem_req_o & ~imem_ack_i) ? DRAIN : FETCH;
        end
    end

    if_fetch_buf u_buf (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .load_i   (load),
        .clear_i  (redirect_i),
        .accept_i (accept),
        .pc_i     (addr_inc),
        .instr_i  (imem_data_i),
        .valid_o  (valid_o),
        .pc_o     (pc_o),
        .instr_o  (instr_o)
    );

`ifdef IF_FETCH_PERF_EN
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            fetch_cnt_o  <= 32'h0;
            bubble_cnt_o <= 32'h0;
        end else if (state != IDLE) begin
            fetch_cnt_o  <= fetch_cnt_o + {31'h0, accept};
            bubble_cnt_o <= bubble_cnt_o + {31'h0, ~valid_o};
        end
    end
`endif
endmodule
